// File: rtl/keypad_scan_pkg.sv
// Shared types and helpers for the 4x4 key matrix scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    REL_CHK
  } state_t;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_SINGLE,
    RES_MULTI
  } frame_res_t;

  // Number of low (pressed) bits in a row sample, saturating at 2 ("many").
  function automatic logic [1:0] countLow(input logic [3:0] rows);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (!rows[i]) n++;
    end
    return (n >= 2) ? 2'd2 : 2'(n);
  endfunction

  // Index of the lowest-numbered low row bit; only meaningful when one is low.
  function automatic logic [1:0] lowestLow(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Matrix pins and decoded key outputs of the keypad scanner.
interface keypad_scan_if;
  import keypad_pkg::*;

  logic [3:0] ROW;
  logic [3:0] COL;
  key_code_t  KEY;
  logic       KEY_VALID;
  logic       KEY_HELD;

  modport master (
    input  ROW,
    output COL, KEY, KEY_VALID, KEY_HELD
  );

  modport slave (
    output ROW,
    input  COL, KEY, KEY_VALID, KEY_HELD
  );

endinterface

// File: rtl/keypad_scan_row_sync.sv
// Two-flop synchronizer; resets to all-ones so idle pulled-up rows read as released.
module row_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Shift the asynchronous rows through two flops before anyone looks at them.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 key matrix scanner: column strobing, per-frame decode and frame-level debounce.
// SCAN_DIV must be at least 4 and DEBOUNCE at least 1.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1024,
  parameter int DEBOUNCE = 4
) (
  input  logic          clock,
  input  logic          nreset,
  keypad_scan_if.master bus
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

  logic [3:0]    rowsSync;
  logic [DW-1:0] dwellCnt_q;
  logic [1:0]    col_q;
  logic [1:0]    accCnt_q;
  key_code_t     accCode_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  key_code_t     cand_q, cand_d;
  key_code_t     key_q, key_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;

  logic          lastDwell;
  logic          frameEnd;
  logic [1:0]    colLow;
  logic [1:0]    lowRow;
  logic [2:0]    accSum;
  logic [1:0]    accCntMerged;
  key_code_t     accCodeMerged;
  frame_res_t    frameRes;
  logic [CW-1:0] cntNext;
  logic          cntDone;

  row_sync #(.WIDTH(4)) uRowSync (
    .clock  (clock),
    .nreset (nreset),
    .async_i(bus.ROW),
    .sync_o (rowsSync)
  );

  assign lastDwell = (dwellCnt_q == DW'(SCAN_DIV - 1));
  assign frameEnd  = lastDwell && (col_q == 2'd3);
  assign colLow    = countLow(rowsSync);
  assign lowRow    = lowestLow(rowsSync);
  assign cntNext   = cnt_q + CW'(1);
  assign cntDone   = (cntNext == CW'(DEBOUNCE));

  // Dwell counter and column pointer; the column advances on the last dwell cycle.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      dwellCnt_q <= '0;
      col_q      <= 2'd0;
    end else if (lastDwell) begin
      dwellCnt_q <= '0;
      col_q      <= col_q + 2'd1;
    end else begin
      dwellCnt_q <= dwellCnt_q + DW'(1);
    end
  end

  // Fold the current column's sample into the running frame count and code.
  always_comb begin
    accSum        = {1'b0, accCnt_q} + {1'b0, colLow};
    accCntMerged  = (accSum >= 3'd2) ? 2'd2 : accSum[1:0];
    accCodeMerged = (accCnt_q == 2'd0 && colLow == 2'd1) ? {lowRow, col_q} : accCode_q;
    case (accCntMerged)
      2'd0:    frameRes = RES_NONE;
      2'd1:    frameRes = RES_SINGLE;
      default: frameRes = RES_MULTI;
    endcase
  end

  // Frame accumulator: update each dwell end, clear after the frame is evaluated.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      accCnt_q  <= 2'd0;
      accCode_q <= '0;
    end else if (frameEnd) begin
      accCnt_q  <= 2'd0;
      accCode_q <= '0;
    end else if (lastDwell) begin
      accCnt_q  <= accCntMerged;
      accCode_q <= accCodeMerged;
    end
  end

  // Debounce state and registered outputs.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  // Debounce decisions, taken only on frame evaluation edges; MULTI never starts a
  // press and never counts toward a release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    key_d   = key_q;
    valid_d = 1'b0;
    held_d  = held_q;
    if (frameEnd) begin
      case (state_q)
        IDLE: begin
          if (frameRes == RES_SINGLE) begin
            cand_d = accCodeMerged;
            if (DEBOUNCE == 1) begin
              key_d   = accCodeMerged;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
              state_d = HELD;
            end else begin
              cnt_d   = CW'(1);
              state_d = PRESS_CHK;
            end
          end
        end
        PRESS_CHK: begin
          if (frameRes == RES_SINGLE && accCodeMerged == cand_q) begin
            if (cntDone) begin
              key_d   = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
              state_d = HELD;
            end else begin
              cnt_d = cntNext;
            end
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        HELD: begin
          if (frameRes == RES_NONE) begin
            if (DEBOUNCE == 1) begin
              held_d  = 1'b0;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d   = CW'(1);
              state_d = REL_CHK;
            end
          end
        end
        REL_CHK: begin
          if (frameRes == RES_NONE) begin
            if (cntDone) begin
              held_d  = 1'b0;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cntNext;
            end
          end else begin
            cnt_d   = '0;
            state_d = HELD;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bus.COL       = ~(4'b0001 << col_q);
  assign bus.KEY       = key_q;
  assign bus.KEY_VALID = valid_q;
  assign bus.KEY_HELD  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan with SCAN_DIV=4, DEBOUNCE=3 (16-cycle frames).
module tb_keypad_scan;
  import keypad_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;

  typedef struct {
    int keyCode;
    int edgeNum;
  } scoreItem_t;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic [15:0] pressed = '0;
  logic        rowForceEn = 1'b0;
  logic [3:0]  rowForce = 4'b1111;
  logic [3:0]  rowModel;
  int          edgeCnt;
  int          vectors = 0;
  int          miscompares = 0;
  scoreItem_t  expQ[$];

  keypad_scan_if kif();

  keypad_scan #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clock (clock),
    .nreset(nreset),
    .bus   (kif)
  );

  always #5 clock = ~clock;

  // Passive matrix model: a pressed key shorts its row low while its column is strobed.
  always_comb begin
    rowModel = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !kif.COL[c]) rowModel[r] = 1'b0;
      end
    end
  end

  assign kif.ROW = rowForceEn ? rowForce : rowModel;

  // Active edges since reset release; frame k is evaluated on edge 16*(k+1).
  always @(posedge clock or negedge nreset) begin
    if (!nreset) edgeCnt <= 0;
    else         edgeCnt <= edgeCnt + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int required);
    vectors++;
    if (actual != required) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d (edge %0d, t=%0t)",
               name, actual, required, edgeCnt, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] mask);
    pressed = mask;
  endtask

  task automatic pushExpect(input int keyCode, input int edgeNum);
    scoreItem_t item;
    item.keyCode = keyCode;
    item.edgeNum = edgeNum;
    expQ.push_back(item);
  endtask

  task automatic waitEdge(input int target);
    while (edgeCnt < target) @(negedge clock);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " COL"}, kif.COL, 4'b1110);
    checkOutput({tag, " KEY"}, kif.KEY, 0);
    checkOutput({tag, " KEY_VALID"}, kif.KEY_VALID, 0);
    checkOutput({tag, " KEY_HELD"}, kif.KEY_HELD, 0);
  endtask

  task automatic resetDut();
    @(negedge clock);
    nreset = 1'b0;
    applyStimulus('0);
    repeat (2) @(negedge clock);
    nreset = 1'b1;
  endtask

  // Monitor: every KEY_VALID pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    scoreItem_t item;
    if (kif.KEY_VALID) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected KEY_VALID", 1, 0);
      end else begin
        item = expQ.pop_front();
        checkOutput("pulse KEY", kif.KEY, item.keyCode);
        checkOutput("pulse edge", edgeCnt, item.edgeNum);
        checkOutput("pulse KEY_HELD", kif.KEY_HELD, 1);
      end
    end
  end

  // Hard time bound so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    logic [3:0] expCol;

    // Reset with wiggling rows, then the column walk.
    $display("[TB] reset and column walk");
    repeat (2) @(negedge clock);
    rowForceEn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rowForce = 4'b0101 ^ 4'(i * 3);
      @(negedge clock);
      checkResetOutputs("in reset");
    end
    rowForceEn = 1'b0;
    nreset = 1'b1;
    for (int n = 0; n < 20; n++) begin
      waitEdge(n);
      expCol = ~(4'b0001 << ((n / 4) % 4));
      checkOutput("COL walk", kif.COL, expCol);
    end

    // Clean press of code 9, one short gap, then full release.
    $display("[TB] clean press, short gap, release");
    resetDut();
    applyStimulus(16'h0001 << 9);
    pushExpect(9, 48);
    waitEdge(47);
    checkOutput("held before accept", kif.KEY_HELD, 0);
    waitEdge(64);
    checkOutput("held key", kif.KEY, 9);
    checkOutput("held level", kif.KEY_HELD, 1);
    waitEdge(80);
    applyStimulus('0);
    waitEdge(96);
    checkOutput("held after one NONE", kif.KEY_HELD, 1);
    applyStimulus(16'h0001 << 9);
    waitEdge(112);
    checkOutput("held after re-press", kif.KEY_HELD, 1);
    waitEdge(128);
    applyStimulus('0);
    waitEdge(160);
    checkOutput("held after two NONE", kif.KEY_HELD, 1);
    waitEdge(176);
    checkOutput("released level", kif.KEY_HELD, 0);
    checkOutput("released key kept", kif.KEY, 9);
    waitEdge(192);

    // Bouncing code 6: present, present, absent, then steady.
    $display("[TB] bounce");
    resetDut();
    applyStimulus(16'h0001 << 6);
    pushExpect(6, 96);
    waitEdge(32);
    applyStimulus('0);
    waitEdge(48);
    applyStimulus(16'h0001 << 6);
    waitEdge(80);
    checkOutput("bounce not yet held", kif.KEY_HELD, 0);
    waitEdge(96);
    checkOutput("bounce key", kif.KEY, 6);
    checkOutput("bounce held", kif.KEY_HELD, 1);
    waitEdge(112);

    // Ghosting: codes 0 and 5 together never produce a press.
    $display("[TB] ghosting");
    resetDut();
    applyStimulus((16'h0001 << 0) | (16'h0001 << 5));
    for (int k = 1; k <= 10; k++) begin
      waitEdge(16 * k);
      checkOutput("ghost held", kif.KEY_HELD, 0);
    end
    applyStimulus('0);

    // Reset in the middle of a code-15 press, key kept down throughout.
    $display("[TB] reset mid-press");
    resetDut();
    applyStimulus(16'h0001 << 15);
    waitEdge(24);
    nreset = 1'b0;
    #1;
    checkResetOutputs("mid-press reset");
    repeat (2) @(negedge clock);
    nreset = 1'b1;
    pushExpect(15, 48);
    waitEdge(40);
    checkOutput("reset press not early", kif.KEY_HELD, 0);
    waitEdge(48);
    checkOutput("reset press key", kif.KEY, 15);
    checkOutput("reset press held", kif.KEY_HELD, 1);
    waitEdge(64);
    applyStimulus('0);

    repeat (20) @(negedge clock);
    checkOutput("scoreboard drained", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scanner for a 4x4 passive key matrix. It is the input-side counterpart of the board's multiplexed seven-segment display driver: it drives one active-low column strobe at a time, samples the active-low row lines, and decodes the result. It debounces the decoded key over whole scan frames and reports a clean 4-bit key code with a one-cycle press strobe and a held level. It sits between the board matrix pins and the CIC control/user logic.

## Interface
Parameters:
- SCAN_DIV, default 1024: clock cycles each column stays strobed. Must be at least 4.
- DEBOUNCE, default 4: consecutive identical frames needed to accept a press or a release. Must be at least 1.

Ports:
- clock  in  1  system clock. Single clock domain.
- nreset  in  1  reset, asynchronous and active-low.
- ROW  in  4  matrix rows, active-low, externally pulled up, asynchronous to clock.
- COL  out  4  column strobes, active-low one-hot.
- KEY  out  4  code of the accepted key, equal to row*4 + col.
- KEY_VALID  out  1  one-cycle pulse when a press is accepted.
- KEY_HELD  out  1  high from press acceptance until release acceptance.

## Operation
- ROW passes through a 2-flop synchronizer. Both flops reset to 4'b1111.
- Column counter col (0..3) selects the strobe: COL = ~(1<<col).
- The dwell counter runs 0..SCAN_DIV-1. On its last cycle:
  - the synchronized rows are sampled into the frame accumulator;
  - col advances, wrapping 3->0.
- One frame is 4 dwells. At the end of the col=3 dwell the frame result is evaluated:
  - NONE: no low row bit in any column.
  - SINGLE(code): exactly one low bit across the whole frame.
  - MULTI: two or more low bits. MULTI is treated as NONE for press detection and as not-NONE for release detection, so ghosting never produces a press and never ends a hold.
- States:
  - IDLE: on SINGLE(c), set cand=c and cnt=1, go to PRESS_CHK.
  - PRESS_CHK: on SINGLE(cand), cnt++. On any other result, go to IDLE. When cnt reaches DEBOUNCE, load KEY=cand, pulse KEY_VALID, set KEY_HELD=1, go to HELD. If DEBOUNCE=1, acceptance happens at the IDLE evaluation itself.
  - HELD: on NONE, set cnt=1 and go to REL_CHK. Any other result stays in HELD. A different single key while held does not re-trigger.
  - REL_CHK: on NONE, cnt++. On a non-NONE result, return to HELD. When cnt reaches DEBOUNCE, clear KEY_HELD and go to IDLE. KEY keeps the last code.
- The frame accumulator clears after each evaluation.
- Reset values:
  - COL=4'b1110, col=0, dwell=0;
  - KEY=0, KEY_VALID=0, KEY_HELD=0;
  - state IDLE, cnt=0.
- Reset mid-operation aborts a pending press or release immediately. No KEY_VALID is emitted.

## Timing
- Frame length is 4*SCAN_DIV cycles. The first frame starts the cycle after nreset deasserts.
- Row sampling uses sync output at dwell index SCAN_DIV-1. This gives SCAN_DIV-3 cycles of settling after the COL change.
- Press latency: a key stable from the start of frame k is accepted at the end of frame k+DEBOUNCE-1.
- KEY and KEY_HELD update in the same cycle as the KEY_VALID pulse.
- KEY_VALID is high for exactly one cycle per accepted press.
- Release latency is DEBOUNCE frames of NONE. KEY_HELD falls the cycle after the final evaluation edge, registered.
- Evaluation, state update and the col 3->0 wrap all occur on the same edge.

## Structure
- Package keypad_pkg holds:
  - enum state_t {IDLE, PRESS_CHK, HELD, REL_CHK};
  - typedef key_code_t, logic[3:0];
  - frame result encoding {RES_NONE, RES_SINGLE, RES_MULTI}.
- One sub-module: row_sync, a parameterized-width 2-flop synchronizer with asynchronous active-low reset to all-ones.
- Scan timing, frame accumulation/evaluation and the debounce FSM stay in keypad_scan.

## Test plan
Bench parameters are SCAN_DIV=4 and DEBOUNCE=3, so a frame is 16 cycles.
- Reset: hold nreset low, toggle ROW. Required: COL=1110, KEY=0, KEY_VALID=0, KEY_HELD=0. After release, COL steps 1110, 1101, 1011, 0111 every 4 cycles, then wraps.
- Clean press: the model pulls ROW[2] low only while COL[1]=0, from frame 0. Required: one KEY_VALID pulse at the end of frame 2, with KEY=9 and KEY_HELD=1. No further pulses while the key is held.
- Bounce: the key for code 6 (row 1, col 2) is present in frames 0 and 1, absent in frame 2, then present from frame 3. Required: no pulse until the end of frame 5, KEY=6.
- Release: after code 9 is held, remove it. Required: KEY_HELD falls after 3 NONE frames and KEY stays 9. A single NONE frame followed by a present frame keeps KEY_HELD=1.
- Ghosting: codes 0 and 5 are pressed together for 10 frames. Required: no KEY_VALID and KEY_HELD=0.
- Reset mid-press: assert nreset during frame 1 of a code-15 press, then keep the key pressed. Required: outputs go to reset values at once. KEY_VALID pulses with KEY=15 at the end of the third full frame after nreset deasserts.
